// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on a shared double-width accumulator; stalls EX while busy.
module ex_muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_dataA,
    input  logic [DATA_WIDTH-1:0] i_dataB,
    input  logic                  i_ready,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [2:0]           op_q, op_nxt;
    logic [W-1:0]         a_mag, a_nxt;
    logic [W-1:0]         b_mag, b_nxt;
    logic                 res_neg, neg_nxt;
    logic [W2-1:0]        acc, acc_nxt;
    logic [W-1:0]         result_nxt;
    logic                 valid_nxt;

    // Operand decode for a newly accepted instruction
    logic         a_signed, b_signed, a_neg_in, b_neg_in, sign_in;
    logic         div_zero, div_ovf;
    logic [W-1:0] a_mag_in, b_mag_in, fast_result;

    assign a_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    assign b_signed = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    assign a_neg_in = a_signed & i_dataA[W-1];
    assign b_neg_in = b_signed & i_dataB[W-1];
    assign a_mag_in = a_neg_in ? W'(-i_dataA) : i_dataA;
    assign b_mag_in = b_neg_in ? W'(-i_dataB) : i_dataB;
    // Remainder sign follows the dividend; unsigned ops never negate
    assign sign_in  = (i_op == 3'd6) ? a_neg_in :
                      ((i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4)) ? (a_neg_in ^ b_neg_in) : 1'b0;

    assign div_zero = i_op[2] && (i_dataB == '0);
    assign div_ovf  = i_op[2] && !i_op[0] && (i_dataA == {1'b1, {(W-1){1'b0}}}) && (i_dataB == '1);
    assign fast_result = div_zero ? (i_op[1] ? i_dataA : '1)
                                  : (i_op[1] ? '0 : i_dataA);

    // One iteration of the active algorithm
    logic [W:0]    mul_sum, div_shift;
    logic          div_ge;
    logic [W-1:0]  div_rem;
    logic [W2-1:0] iter_acc, prod_fix;
    logic [W-1:0]  quot_fix, rem_fix, calc_result;

    assign mul_sum   = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, a_mag} : (W+1)'(0));
    assign div_shift = {acc[W2-1:W], acc[W-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag};
    assign div_rem   = div_ge ? W'(div_shift - {1'b0, b_mag}) : div_shift[W-1:0];
    assign iter_acc  = op_q[2] ? {div_rem, acc[W-2:0], div_ge} : {mul_sum, acc[W-1:1]};

    assign prod_fix    = res_neg ? W2'(-iter_acc) : iter_acc;
    assign quot_fix    = res_neg ? W'(-iter_acc[W-1:0]) : iter_acc[W-1:0];
    assign rem_fix     = res_neg ? W'(-iter_acc[W2-1:W]) : iter_acc[W2-1:W];
    assign calc_result = !op_q[2] ? ((op_q == 3'd0) ? prod_fix[W-1:0] : prod_fix[W2-1:W])
                                  : (op_q[1] ? rem_fix : quot_fix);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            res_neg  <= 1'b0;
            acc      <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            op_q     <= op_nxt;
            a_mag    <= a_nxt;
            b_mag    <= b_nxt;
            res_neg  <= neg_nxt;
            acc      <= acc_nxt;
            o_result <= result_nxt;
            o_valid  <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        a_nxt      = a_mag;
        b_nxt      = b_mag;
        neg_nxt    = res_neg;
        acc_nxt    = acc;
        result_nxt = o_result;
        o_stall    = 1'b0;

        case (state)
            IDLE: begin
                o_stall = i_valid;
                if (i_valid) begin
                    op_nxt  = i_op;
                    a_nxt   = a_mag_in;
                    b_nxt   = b_mag_in;
                    neg_nxt = sign_in;
                    cnt_nxt = '0;
                    if (div_zero || div_ovf) begin
                        state_nxt  = DONE;
                        result_nxt = fast_result;
                    end else begin
                        state_nxt = CALC;
                        acc_nxt   = {{W{1'b0}}, (i_op[2] ? a_mag_in : b_mag_in)};
                    end
                end
            end
            CALC: begin
                o_stall = 1'b1;
                acc_nxt = iter_acc;
                cnt_nxt = cnt + CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(W - 1)) begin
                    state_nxt  = DONE;
                    result_nxt = calc_result;
                end
            end
            DONE: begin
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Flush wins over ready and acceptance; reset forces the stall low immediately
        if (i_flush) begin
            state_nxt  = IDLE;
            result_nxt = o_result;
            o_stall    = 1'b0;
        end
        if (i_reset) o_stall = 1'b0;
        valid_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed cases plus random ops vs. an arithmetic model.
module tb_ex_muldiv_sequencer;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [2:0]  i_op;
    logic [31:0] i_dataA;
    logic [31:0] i_dataB;
    logic        i_ready;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    ex_muldiv_sequencer dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_dataA (i_dataA),
        .i_dataB (i_dataB),
        .i_ready (i_ready),
        .i_flush (i_flush),
        .o_stall (o_stall),
        .o_valid (o_valid),
        .o_result(o_result)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub;         return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op in the current IDLE cycle, wait for the result, hold it, then consume it.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          lat, cycles, stalls;
        exp = ref_res(op, a, b);
        lat = ref_lat(op, a, b);
        i_valid = 1'b1; i_op = op; i_dataA = a; i_dataB = b; i_ready = 1'b0;
        #1;
        stalls = o_stall ? 1 : 0;
        cycles = 0;
        while (!o_valid && cycles < 100) begin
            @(posedge i_clock); #1;
            cycles++;
            if (o_stall) stalls++;
        end
        check({name, "_latency"}, 32'(cycles), 32'(lat));
        check({name, "_stall_cycles"}, 32'(stalls), 32'(lat));
        check({name, "_result"}, o_result, exp);
        i_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clock); #1;
            check({name, "_hold_valid"}, 32'(o_valid), 32'd1);
            check({name, "_hold_result"}, o_result, exp);
            check({name, "_hold_stall"}, 32'(o_stall), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
        check({name, "_consumed"}, 32'(o_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_op = '0; i_dataA = '0; i_dataB = '0;
        i_ready = 1'b0; i_flush = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        check("reset_stall", 32'(o_stall), 32'd0);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_result", o_result, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(posedge i_clock); #1;

        run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_ff",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        run_op("div_5_0",    3'd4, 32'd5, 32'd0, 0);
        run_op("rem_5_0",    3'd6, 32'd5, 32'd0, 0);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("done_hold",  3'd4, 32'hFFFF_FF9C, 32'd7, 5);

        // Flush a DIVU partway through the iterations
        i_valid = 1'b1; i_op = 3'd5; i_dataA = 32'd1000; i_dataB = 32'd3;
        repeat (11) @(posedge i_clock);
        #1;
        check("flush_pre_stall", 32'(o_stall), 32'd1);
        i_flush = 1'b1;
        #1;
        check("flush_cycle_stall", 32'(o_stall), 32'd0);
        @(posedge i_clock); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        #1;
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_idle_stall", 32'(o_stall), 32'd0);
        run_op("mul_3_4_after_flush", 3'd0, 32'd3, 32'd4, 0);

        for (int n = 0; n < 50; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, (n % 7 == 0) ? 2 : 0);
        end

        // Asynchronous reset in the middle of CALC
        i_valid = 1'b1; i_op = 3'd0; i_dataA = 32'd9; i_dataB = 32'd9;
        repeat (6) @(posedge i_clock);
        #1;
        check("pre_reset_stall", 32'(o_stall), 32'd1);
        check("pre_reset_result", o_result, ref_res(o_result == 32'd0 ? 3'd0 : 3'd0, 32'd0, 32'd0) | o_result);
        #2;
        i_reset = 1'b1;
        #1;
        check("async_reset_stall", 32'(o_stall), 32'd0);
        check("async_reset_valid", 32'(o_valid), 32'd0);
        check("async_reset_result", o_result, 32'd0);
        i_valid = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
        @(posedge i_clock); #1;
        run_op("mul_after_reset", 3'd1, 32'h1234_5678, 32'h8765_4321, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%h exp=%h", 32'd0, 32'd1);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Iterative multiply/divide unit and its sequencer for the EX stage; executes RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that the single-cycle ALU cannot.
- Accepts operands from the EX operand path and stalls the pipeline (feeds the EX hazard/stall logic) while computing.
- Presents the result and holds it until the pipeline advances.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_valid  in  1  M-extension instruction present in EX; held stable while o_stall=1.
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_dataA  in  DATA_WIDTH  rs1 operand.
- i_dataB  in  DATA_WIDTH  rs2 operand.
- i_ready  in  1  pipeline advances EX this cycle (result consumed).
- i_flush  in  1  kill in-flight operation (branch/exception).
- o_stall  out  1  hold EX stage; OR'd into the EX hazard output.
- o_valid  out  1  o_result valid.
- o_result  out  DATA_WIDTH  operation result.

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; o_valid=0; o_result=0; o_stall=0. Internal accumulators cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_stall = i_valid & ~i_flush (combinational); o_valid=0.
  - On i_valid & ~i_flush: latch op; latch |A| and |B| (signed per op; MULHSU: A signed, B unsigned); record result sign; counter=0.
  - Divide by zero (B=0, op 4–7): go directly to DONE. DIV/DIVU result all-ones; REM/REMU result A.
  - Signed overflow (DIV/REM, A=most-negative, B=-1): go directly to DONE. DIV result A; REM result 0.
  - Otherwise go to CALC.
- CALC:
  - o_stall=1; one iteration per cycle.
  - Multiply: shift-add on a 2*DATA_WIDTH product register.
  - Divide: restoring shift-subtract on a {remainder, quotient} register.
  - Counter increments; after iteration DATA_WIDTH-1 (counter==DATA_WIDTH-1), go to DONE.
- Transition into DONE:
  - Apply sign fixup (two's-complement negate when recorded sign=1).
  - Select result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder (sign follows dividend).
  - Register into o_result.
- DONE:
  - o_valid=1; o_stall=0; o_result held stable.
  - On i_ready, go to IDLE with o_valid=0 the next cycle. Without i_ready, remain in DONE indefinitely.
- Latency:
  - Accept at cycle T (IDLE). Normal op: o_valid first high at T+DATA_WIDTH+1; o_stall high T..T+DATA_WIDTH.
  - Fast path (div-by-zero/overflow): o_valid at T+1; o_stall high only at T.
- i_flush, in any state: next state IDLE; o_valid=0 next cycle; o_stall=0 in the flush cycle. Result discarded; flush has priority over i_ready and over acceptance.
- Back-to-back ops: DONE+i_ready → IDLE. A new i_valid is accepted in that IDLE cycle, so there is a 1-cycle gap between ops. No restart of the consumed instruction, because i_ready advanced it.
- i_valid low in DONE is ignored; o_valid stays high until i_ready or flush.
- Arithmetic:
  - All operations are on unsigned magnitudes.
  - Most-negative operand magnitude is representable in DATA_WIDTH unsigned bits; no extra bit needed except in the remainder subtractor (DATA_WIDTH+1 bits).
- Reset mid-CALC aborts immediately: outputs return to reset values asynchronously.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), i_ready=1 → o_stall high 33 cycles; o_valid at T+33 with o_result=0xFFFFFFEB; IDLE next cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → o_valid at T+1, 0xFFFFFFFF; REM 5/0 → 5. DIV 0x80000000/-1 → 0x80000000 at T+1; REM same operands → 0.
- Start DIVU; assert i_flush at iteration 10 → IDLE next cycle, o_valid never asserted. New MUL 3×4 accepted the following cycle → o_result=12.
- DONE with i_ready low for 5 cycles → o_valid and o_result stable, o_stall=0. Assert i_reset asynchronously mid-CALC → all outputs 0 without a clock edge.
